// File: rtl/interrupt_router.sv
// interrupt_router: synchronises N active-low interrupt sources, captures them
// as level or edge requests and routes each one onto nNMI, nIRQ or nFIRQ of a
// 6809. A global mask forces the CPU lines inactive and, once it is released,
// keeps them inactive for a programmable hold-off window.
//
// Register map (bits at or above N_SRC read 0 and ignore writes):
//   0 MODE    1 = edge, 0 = level
//   1 ENABLE
//   2 ROUTE[7:0], 3 ROUTE[15:8]  two bits per source: 00 IRQ, 01 FIRQ, 10 NMI, 11 none
//   4 PENDING read, write-1-to-clear for edge sources
//   5-7 read 0
module interrupt_router #(
    parameter int          N_SRC       = 3,
    parameter int          SYNC_STAGES = 2,
    parameter int          HOLDOFF     = 8,
    parameter logic [15:0] ROUTE_INIT  = 16'hFFD2
) (
    input  logic             clk,
    input  logic             nRESET,
    input  logic [N_SRC-1:0] nSRC,
    input  logic             mask,
    input  logic             wr_en,
    input  logic [2:0]       addr,
    input  logic [7:0]       wr_data,
    output logic [7:0]       rd_data,
    output logic             nNMI,
    output logic             nIRQ,
    output logic             nFIRQ
);

    // A hold-off of zero still needs a one-bit counter that simply stays at 0.
    localparam int            CW        = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLDOFF);

    localparam logic [1:0] R_IRQ  = 2'b00;
    localparam logic [1:0] R_FIRQ = 2'b01;
    localparam logic [1:0] R_NMI  = 2'b10;

    localparam logic [2*N_SRC-1:0] ROUTE_RST = ROUTE_INIT[2*N_SRC-1:0];

    logic [SYNC_STAGES-1:0][N_SRC-1:0] sync_q, sync_d;
    logic [N_SRC-1:0]   s_w;
    logic [N_SRC-1:0]   p_q;
    logic [N_SRC-1:0]   mode_q, mode_d;
    logic [N_SRC-1:0]   enable_q, enable_d;
    logic [N_SRC-1:0]   pending_q, pending_d;
    logic [2*N_SRC-1:0] route_q, route_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               nnmi_q, nirq_q, nfirq_q;

    logic               wr_mode, wr_enable, wr_route_lo, wr_route_hi, wr_pending;
    logic [15:0]        route_full_q;
    logic [15:0]        route_full_w;
    logic               req_nmi, req_irq, req_firq;
    logic               gate;

    assign wr_mode     = wr_en && (addr == 3'd0);
    assign wr_enable   = wr_en && (addr == 3'd1);
    assign wr_route_lo = wr_en && (addr == 3'd2);
    assign wr_route_hi = wr_en && (addr == 3'd3);
    assign wr_pending  = wr_en && (addr == 3'd4);

    assign s_w  = sync_q[SYNC_STAGES-1];
    assign gate = mask || (cnt_q != '0);

    assign nNMI  = nnmi_q;
    assign nIRQ  = nirq_q;
    assign nFIRQ = nfirq_q;

    // Synchroniser shift: stage 0 samples the raw pins.
    always_comb begin
        sync_d[0] = nSRC;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    // ROUTE is kept only for implemented sources; a 16-bit view serves both byte ports.
    always_comb begin
        route_full_q                = 16'h0000;
        route_full_q[2*N_SRC-1:0]   = route_q;
        route_full_w                = route_full_q;
        if (wr_route_lo) route_full_w[7:0]  = wr_data;
        if (wr_route_hi) route_full_w[15:8] = wr_data;
        route_d = route_full_w[2*N_SRC-1:0];
    end

    // MODE / ENABLE write decode.
    always_comb begin
        mode_d   = wr_mode   ? wr_data[N_SRC-1:0] : mode_q;
        enable_d = wr_enable ? wr_data[N_SRC-1:0] : enable_q;
    end

    // Pending capture: level follows the pin, edge latches until cleared (set beats clear).
    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < N_SRC; i++) begin
            if (wr_mode && (wr_data[i] != mode_q[i])) begin
                pending_d[i] = 1'b0;
            end else if (!mode_q[i]) begin
                pending_d[i] = enable_q[i] & ~s_w[i];
            end else if (!enable_q[i] || (wr_enable && !wr_data[i])) begin
                pending_d[i] = 1'b0;
            end else if (p_q[i] && !s_w[i]) begin
                pending_d[i] = 1'b1;
            end else if (wr_pending && wr_data[i]) begin
                pending_d[i] = 1'b0;
            end
        end
    end

    // Per-line request: wired-OR of pending sources whose route code selects the line.
    always_comb begin
        req_nmi  = 1'b0;
        req_irq  = 1'b0;
        req_firq = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (pending_q[i] && (route_q[2*i +: 2] == R_NMI))  req_nmi  = 1'b1;
            if (pending_q[i] && (route_q[2*i +: 2] == R_IRQ))  req_irq  = 1'b1;
            if (pending_q[i] && (route_q[2*i +: 2] == R_FIRQ)) req_firq = 1'b1;
        end
    end

    // Hold-off counter: reloads while masked, drains to zero once mask drops.
    always_comb begin
        if (mask) begin
            cnt_d = HOLD_LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end else begin
            cnt_d = '0;
        end
    end

    // Combinational register read; reads have no side effects.
    always_comb begin
        rd_data = 8'h00;
        case (addr)
            3'd0:    rd_data[N_SRC-1:0] = mode_q;
            3'd1:    rd_data[N_SRC-1:0] = enable_q;
            3'd2:    rd_data            = route_full_q[7:0];
            3'd3:    rd_data            = route_full_q[15:8];
            3'd4:    rd_data[N_SRC-1:0] = pending_q;
            default: rd_data            = 8'h00;
        endcase
    end

    // State registers; reset forces every CPU line inactive asynchronously.
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            sync_q    <= '1;
            p_q       <= '1;
            mode_q    <= '0;
            enable_q  <= '1;
            pending_q <= '0;
            route_q   <= ROUTE_RST;
            cnt_q     <= '0;
            nnmi_q    <= 1'b1;
            nirq_q    <= 1'b1;
            nfirq_q   <= 1'b1;
        end else begin
            sync_q    <= sync_d;
            p_q       <= s_w;
            mode_q    <= mode_d;
            enable_q  <= enable_d;
            pending_q <= pending_d;
            route_q   <= route_d;
            cnt_q     <= cnt_d;
            nnmi_q    <= gate ? 1'b1 : ~req_nmi;
            nirq_q    <= gate ? 1'b1 : ~req_irq;
            nfirq_q   <= gate ? 1'b1 : ~req_firq;
        end
    end

endmodule

// File: tb/tb_interrupt_router.sv
// tb_interrupt_router: directed scenarios followed by randomized traffic, all
// compared against a behavioural model of the router kept in this file.
module tb_interrupt_router;

    localparam int N_SRC = 3;
    localparam int SS    = 2;
    localparam int HOLD  = 8;
    localparam logic [15:0] RINIT = 16'hFFD2;

    logic             clk = 1'b0;
    logic             nRESET;
    logic [N_SRC-1:0] nsrc;
    logic             mask;
    logic             wr_en;
    logic [2:0]       addr;
    logic [7:0]       wr_data;
    logic [7:0]       rd_data;
    logic             nNMI, nIRQ, nFIRQ;

    int errors = 0;
    int checks = 0;

    // Model state
    logic [N_SRC-1:0]   m_mode, m_en, m_pend;
    logic [2*N_SRC-1:0] m_route;
    logic [N_SRC-1:0]   hist[$];
    int                 m_since_mask;
    logic [2:0]         m_out; // {nNMI, nIRQ, nFIRQ}

    interrupt_router #(
        .N_SRC(N_SRC), .SYNC_STAGES(SS), .HOLDOFF(HOLD), .ROUTE_INIT(RINIT)
    ) dut (
        .clk(clk), .nRESET(nRESET), .nSRC(nsrc), .mask(mask),
        .wr_en(wr_en), .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
        .nNMI(nNMI), .nIRQ(nIRQ), .nFIRQ(nFIRQ)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode       = '0;
        m_en         = '1;
        m_pend       = '0;
        m_route      = RINIT[2*N_SRC-1:0];
        m_since_mask = HOLD;
        m_out        = 3'b111;
        hist.delete();
        for (int k = 0; k <= SS; k++) hist.push_back('1);
    endtask

    function automatic logic [7:0] m_read(input logic [2:0] a);
        logic [15:0] r;
        logic [7:0]  v;
        r = 16'h0;
        r[2*N_SRC-1:0] = m_route;
        v = 8'h00;
        case (a)
            3'd0: v[N_SRC-1:0] = m_mode;
            3'd1: v[N_SRC-1:0] = m_en;
            3'd2: v = r[7:0];
            3'd3: v = r[15:8];
            3'd4: v[N_SRC-1:0] = m_pend;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    // One clock edge of the reference: outputs from the pending set seen
    // before the edge, then pending/register/hold-off bookkeeping.
    task automatic model_edge();
        logic             gated;
        logic [2:0]       req;
        logic [N_SRC-1:0] s, p, np;
        logic [15:0]      r;
        logic [1:0]       code;
        gated = mask || (m_since_mask < HOLD);
        req = 3'b000;
        for (int i = 0; i < N_SRC; i++) begin
            code = m_route[2*i +: 2];
            if (m_pend[i]) begin
                if (code == 2'b10) req[2] = 1'b1;
                if (code == 2'b00) req[1] = 1'b1;
                if (code == 2'b01) req[0] = 1'b1;
            end
        end
        m_out = gated ? 3'b111 : ~req;

        // Pin as seen after synchronisation, and one clock older.
        s = hist[SS-1];
        p = hist[SS];
        np = m_pend;
        for (int i = 0; i < N_SRC; i++) begin
            if (wr_en && addr == 3'd0 && wr_data[i] != m_mode[i]) np[i] = 1'b0;
            else if (!m_mode[i]) np[i] = m_en[i] && !s[i];
            else if (!m_en[i] || (wr_en && addr == 3'd1 && !wr_data[i])) np[i] = 1'b0;
            else if (p[i] && !s[i]) np[i] = 1'b1;
            else if (wr_en && addr == 3'd4 && wr_data[i]) np[i] = 1'b0;
        end
        m_pend = np;

        if (wr_en) begin
            r = 16'h0;
            r[2*N_SRC-1:0] = m_route;
            case (addr)
                3'd0: m_mode = wr_data[N_SRC-1:0];
                3'd1: m_en   = wr_data[N_SRC-1:0];
                3'd2: r[7:0]  = wr_data;
                3'd3: r[15:8] = wr_data;
                default: ;
            endcase
            m_route = r[2*N_SRC-1:0];
        end

        if (mask) m_since_mask = 0;
        else if (m_since_mask < HOLD) m_since_mask++;

        hist.push_front(nsrc);
        void'(hist.pop_back());
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("nNMI_model",  {7'd0, nNMI},  {7'd0, m_out[2]});
        chk("nIRQ_model",  {7'd0, nIRQ},  {7'd0, m_out[1]});
        chk("nFIRQ_model", {7'd0, nFIRQ}, {7'd0, m_out[0]});
        chk("rd_model",    rd_data,       m_read(addr));
    endtask

    task automatic write_reg(input logic [2:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        addr    = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
        wr_data = 8'h00;
    endtask

    initial begin
        nRESET  = 1'b0;
        nsrc    = '1;
        mask    = 1'b0;
        wr_en   = 1'b0;
        addr    = 3'd0;
        wr_data = 8'h00;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_nNMI",  {7'd0, nNMI},  8'h01);
        chk("rst_nIRQ",  {7'd0, nIRQ},  8'h01);
        chk("rst_nFIRQ", {7'd0, nFIRQ}, 8'h01);
        addr = 3'd1; #1; chk("rst_enable", rd_data, 8'h07);
        addr = 3'd2; #1; chk("rst_route_lo", rd_data, 8'h12);
        addr = 3'd3; #1; chk("rst_route_hi", rd_data, 8'h00);
        addr = 3'd0; #1; chk("rst_mode", rd_data, 8'h00);
        nRESET = 1'b1;
        repeat (9) tick();

        // Level source 1 -> nIRQ after SYNC_STAGES+2 clocks
        nsrc[1] = 1'b0;
        repeat (3) tick();
        chk("lvl_lat_before", {7'd0, nIRQ}, 8'h01);
        tick();
        chk("lvl_lat_nIRQ",  {7'd0, nIRQ},  8'h00);
        chk("lvl_lat_nNMI",  {7'd0, nNMI},  8'h01);
        chk("lvl_lat_nFIRQ", {7'd0, nFIRQ}, 8'h01);
        addr = 3'd4; #1; chk("lvl_pending", rd_data, 8'h02);

        // Mask with hold-off
        mask = 1'b1;
        tick();
        chk("mask_gate", {7'd0, nIRQ}, 8'h01);
        repeat (4) tick();
        mask = 1'b0;
        for (int k = 0; k < HOLD; k++) begin
            tick();
            chk("holdoff", {7'd0, nIRQ}, 8'h01);
        end
        tick();
        chk("holdoff_release", {7'd0, nIRQ}, 8'h00);
        nsrc[1] = 1'b1;
        repeat (5) tick();
        chk("lvl_release", {7'd0, nIRQ}, 8'h01);

        // Edge mode on src0 routed to IRQ
        write_reg(3'd0, 8'h01);
        write_reg(3'd2, 8'hD0);
        nsrc[0] = 1'b0;
        tick();
        nsrc[0] = 1'b1;
        repeat (6) tick();
        chk("edge_held", {7'd0, nIRQ}, 8'h00);
        addr = 3'd4; #1; chk("edge_pending", rd_data, 8'h01);
        write_reg(3'd4, 8'h01);
        chk("edge_clr_same", {7'd0, nIRQ}, 8'h00);
        tick();
        chk("edge_clr_rise", {7'd0, nIRQ}, 8'h01);

        // Set/clear collision: set wins
        repeat (3) tick();
        nsrc[0] = 1'b0;
        tick();
        tick();
        write_reg(3'd4, 8'h01);
        addr = 3'd4; #1; chk("coll_pending", rd_data, 8'h01);
        tick();
        chk("coll_nIRQ", {7'd0, nIRQ}, 8'h00);
        nsrc[0] = 1'b1;
        repeat (3) tick();
        chk("coll_nIRQ_hold", {7'd0, nIRQ}, 8'h00);

        // Routing all sources to FIRQ, then src2 to none
        write_reg(3'd0, 8'h00);
        write_reg(3'd2, 8'h55);
        write_reg(3'd3, 8'hFF);
        repeat (3) tick();
        nsrc[2] = 1'b0;
        repeat (4) tick();
        chk("route_nFIRQ", {7'd0, nFIRQ}, 8'h00);
        chk("route_nIRQ",  {7'd0, nIRQ},  8'h01);
        chk("route_nNMI",  {7'd0, nNMI},  8'h01);
        write_reg(3'd2, 8'h75);
        tick();
        chk("route_none_nFIRQ", {7'd0, nFIRQ}, 8'h01);
        addr = 3'd4; #1; chk("route_none_pending", rd_data, 8'h04);

        // Async reset mid-request
        write_reg(3'd2, 8'hD2);
        nsrc[2] = 1'b1;
        nsrc[1] = 1'b0;
        repeat (6) tick();
        chk("arst_pre_nIRQ", {7'd0, nIRQ}, 8'h00);
        #3;
        nRESET = 1'b0;
        model_reset();
        #1;
        chk("arst_nNMI",  {7'd0, nNMI},  8'h01);
        chk("arst_nIRQ",  {7'd0, nIRQ},  8'h01);
        chk("arst_nFIRQ", {7'd0, nFIRQ}, 8'h01);
        nsrc = '1;
        @(posedge clk);
        #3;
        nRESET = 1'b1;
        repeat (6) tick();
        chk("arst_after_nIRQ", {7'd0, nIRQ}, 8'h01);
        addr = 3'd4; #1; chk("arst_after_pending", rd_data, 8'h00);

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N_SRC; i++) begin
                if ($urandom_range(0, 7) == 0) nsrc[i] = ~nsrc[i];
            end
            if (mask) mask = ($urandom_range(0, 3) != 0);
            else      mask = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 5) == 0) begin
                wr_en   = 1'b1;
                addr    = 3'($urandom_range(0, 7));
                wr_data = 8'($urandom);
                if (addr == 3'd1 && $urandom_range(0, 1) == 1) wr_data = 8'hFF;
            end else begin
                wr_en   = 1'b0;
                addr    = 3'($urandom_range(0, 7));
                wr_data = 8'h00;
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
